// File: rtl/branch_resolve.sv
// ----------------------------------------------------------------------------
// branch_resolve
//   Execute-stage branch resolution. Consumes the registered comparator flags
//   (eq / gts / gtu) with the branch funct3, PC, immediate and fetch
//   prediction. Decides taken / not-taken, computes the architecturally
//   correct next PC, flags mispredicts and holds a redirect request towards
//   fetch until fetch acknowledges it.
//
//   Ports
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     in_valid/in_ready   op handshake; in_funct3, in_eq, in_gts, in_gtu,
//                         in_pc, in_imm, in_pred_taken are the op payload
//     flush               synchronous kill of a held, non-mispredicted result
//     out_valid/out_ready result handshake; out_taken, out_mispredict,
//                         out_illegal, out_next_pc are the result payload
//     redir_valid/redir_ack, redir_pc  redirect request to fetch
//
//   Optional build macro BRANCH_STATS_EN adds stat_clr, stat_branches and
//   stat_mispredicts (saturating 32-bit op / mispredict counters).
// ----------------------------------------------------------------------------
module branch_resolve #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_eq,
  input  logic            in_gts,
  input  logic            in_gtu,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_pred_taken,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic            out_mispredict,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_next_pc,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  input  logic            redir_ack
`ifdef BRANCH_STATS_EN
  ,
  input  logic            stat_clr,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RESP, S_REDIR} state_t;

  function automatic logic cond_taken(input logic [2:0] f3, input logic eq,
                                      input logic gts, input logic gtu);
    logic t;
    case (f3)
      3'b000:  t = eq;
      3'b001:  t = !eq;
      3'b100:  t = !gts && !eq;
      3'b101:  t = gts || eq;
      3'b110:  t = !gtu && !eq;
      3'b111:  t = gtu || eq;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic is_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  // The offset is a signed quantity, but two's-complement addition modulo
  // 2^XLEN is identical to the unsigned add, so the wrap is silent.
  function automatic logic [XLEN-1:0] target_pc(input logic [XLEN-1:0] pc,
                                                input logic signed [XLEN-1:0] imm,
                                                input logic taken);
    return taken ? (pc + $unsigned(imm)) : (pc + XLEN'(4));
  endfunction

  state_t          state;
  logic            taken_p0, ill_p0, mis_p0;
  logic [XLEN-1:0] npc_p0;
  logic            taken_p1, ill_p1, mis_p1;
  logic [XLEN-1:0] npc_p1;
  logic            vld_p1;
  logic            ack_seen;
  logic            accept;

  // ---- stage p0: combinational resolve of the presented op ----
  always_comb begin
    taken_p0 = cond_taken(in_funct3, in_eq, in_gts, in_gtu);
    ill_p0   = is_illegal(in_funct3);
    mis_p0   = taken_p0 ^ in_pred_taken;
    npc_p0   = target_pc(in_pc, $signed(in_imm), taken_p0);
  end

  // A mispredicted result never releases in_ready: the redirect must be
  // handed to fetch before the next op may be resolved.
  always_comb begin
    case (state)
      S_IDLE:  in_ready = !flush;
      S_RESP:  in_ready = !mis_p1 && out_ready && !flush;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  // ---- stage p1: registered result and handshake FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ack_seen <= 1'b0;
      taken_p1 <= 1'b0;
      ill_p1   <= 1'b0;
      mis_p1   <= 1'b0;
      npc_p1   <= '0;
    end else begin
      if (accept) begin
        taken_p1 <= taken_p0;
        ill_p1   <= ill_p0;
        mis_p1   <= mis_p0;
        npc_p1   <= npc_p0;
        ack_seen <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (accept) state <= S_RESP;
        end
        S_RESP: begin
          if (mis_p1) begin
            // Fetch may acknowledge before the result is consumed; remember it.
            ack_seen <= ack_seen || redir_ack;
            if (out_ready) state <= (ack_seen || redir_ack) ? S_IDLE : S_REDIR;
          end else if (accept) begin
            state <= S_RESP;
          end else if (out_ready || flush) begin
            state <= S_IDLE;
          end
        end
        S_REDIR: begin
          if (redir_ack) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign vld_p1         = (state == S_RESP);
  assign out_valid      = vld_p1;
  assign out_taken      = taken_p1;
  assign out_mispredict = mis_p1;
  assign out_illegal    = ill_p1;
  assign out_next_pc    = npc_p1;
  assign redir_pc       = npc_p1;
  assign redir_valid    = (vld_p1 && mis_p1 && !ack_seen) || (state == S_REDIR);

`ifdef BRANCH_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (stat_clr) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (accept) begin
      stat_branches <= sat_inc(stat_branches);
      if (mis_p0) stat_mispredicts <= sat_inc(stat_mispredicts);
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      in_funct3 = 3'b000;
  logic            in_eq = 1'b0, in_gts = 1'b0, in_gtu = 1'b0;
  logic [XLEN-1:0] in_pc = '0, in_imm = '0;
  logic            in_pred_taken = 1'b0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            out_taken, out_mispredict, out_illegal;
  logic [XLEN-1:0] out_next_pc;
  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;
  logic            redir_ack = 1'b0;
`ifdef BRANCH_STATS_EN
  logic            stat_clr = 1'b0;
  logic [31:0]     stat_branches, stat_mispredicts;
`endif

  branch_resolve #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_eq(in_eq), .in_gts(in_gts), .in_gtu(in_gtu),
    .in_pc(in_pc), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_mispredict(out_mispredict),
    .out_illegal(out_illegal), .out_next_pc(out_next_pc),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ack(redir_ack)
`ifdef BRANCH_STATS_EN
    , .stat_clr(stat_clr), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  f3;
    logic        eq, gts, gtu;
    logic [31:0] pc, imm;
    logic        pred;
    logic        taken, mis, ill;
    logic [31:0] npc;
  } vec_t;

  vec_t tbl[14];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;
  logic chk_redir = 1'b0;

  function automatic vec_t mk(logic [2:0] f3, logic eq, logic gts, logic gtu,
                              logic [31:0] pc, logic [31:0] imm, logic pred,
                              logic taken, logic mis, logic ill, logic [31:0] npc);
    vec_t v;
    v.f3 = f3; v.eq = eq; v.gts = gts; v.gtu = gtu; v.pc = pc; v.imm = imm;
    v.pred = pred; v.taken = taken; v.mis = mis; v.ill = ill; v.npc = npc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input vec_t v);
    int n;
    in_funct3 = v.f3; in_eq = v.eq; in_gts = v.gts; in_gtu = v.gtu;
    in_pc = v.pc; in_imm = v.imm; in_pred_taken = v.pred; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
    else exp_q.push_back(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          vec_t e;
          e = exp_q.pop_front();
          check("result{taken,mis,ill,npc}",
                {out_taken, out_mispredict, out_illegal, out_next_pc},
                {e.taken, e.mis, e.ill, e.npc});
          if (chk_redir)
            check("redir{valid,pc}", {redir_valid, (redir_valid ? redir_pc : 32'h0)},
                  {e.mis, (e.mis ? e.npc : 32'h0)});
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v, dummy;
    int start;
    //      f3     eq gts gtu pc            imm           pred tk mis ill npc
    tbl[0]  = mk(3'b000, 1, 0, 0, 32'h1000, 32'h20,       1, 1, 0, 0, 32'h1020);
    tbl[1]  = mk(3'b000, 0, 0, 0, 32'h1000, 32'h20,       1, 0, 1, 0, 32'h1004);
    tbl[2]  = mk(3'b001, 0, 0, 1, 32'h3000, 32'hFFFFFFF0, 1, 1, 0, 0, 32'h2FF0);
    tbl[3]  = mk(3'b100, 0, 1, 0, 32'h2000, 32'h40,       1, 0, 1, 0, 32'h2004);
    tbl[4]  = mk(3'b100, 0, 0, 1, 32'h2000, 32'h40,       0, 1, 1, 0, 32'h2040);
    tbl[5]  = mk(3'b101, 1, 0, 0, 32'h100,  32'h8,        1, 1, 0, 0, 32'h108);
    tbl[6]  = mk(3'b101, 0, 0, 1, 32'h100,  32'h8,        0, 0, 0, 0, 32'h104);
    tbl[7]  = mk(3'b110, 0, 1, 0, 32'h500,  32'h100,      0, 1, 1, 0, 32'h600);
    tbl[8]  = mk(3'b110, 1, 0, 0, 32'h500,  32'h100,      0, 0, 0, 0, 32'h504);
    tbl[9]  = mk(3'b111, 1, 0, 0, 32'hFFFFFFF8, 32'h10,   1, 1, 0, 0, 32'h8);
    tbl[10] = mk(3'b111, 0, 1, 0, 32'h40,   32'h10,       1, 0, 1, 0, 32'h44);
    tbl[11] = mk(3'b011, 1, 0, 0, 32'h700,  32'h10,       0, 0, 0, 1, 32'h704);
    tbl[12] = mk(3'b010, 1, 1, 1, 32'h700,  32'h10,       1, 0, 1, 1, 32'h704);
    tbl[13] = mk(3'b001, 1, 0, 0, 32'hFFFFFFFC, 32'h40,   0, 0, 0, 0, 32'h0);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset{ov,rv,tk,mis,ill}",
          {out_valid, redir_valid, out_taken, out_mispredict, out_illegal}, 64'd0);
    check("reset{npc,rpc}", {out_next_pc, redir_pc}, 64'd0);
`ifdef BRANCH_STATS_EN
    check("reset_stats", {stat_branches, stat_mispredicts}, 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    tick();
    fork
      monitor_loop();
    join_none

    // Decode table, fully handshaken outputs
    chk_redir = 1'b1; out_ready = 1'b1; redir_ack = 1'b1;
    for (int i = 0; i < 14; i++) drive_op(tbl[i]);
    drain();
    chk_redir = 1'b0; redir_ack = 1'b0;

    // Back-to-back BNE ops: one accept per cycle
    start = cyc;
    for (int i = 0; i < 4; i++) begin
      v = mk(3'b001, 0, 0, 0, 32'h4000 + 32'(i * 16), 32'h80, 1, 1, 0, 0,
             32'h4080 + 32'(i * 16));
      drive_op(v);
    end
    check("b2b_cycles", 64'(cyc - start), 64'd4);
    drain();

    // Mispredict with redir_ack held off: RESP -> REDIR -> IDLE
    drive_op(tbl[3]);
    @(negedge clk);
    check("redir_resp{ov,rv,rpc}", {out_valid, redir_valid, redir_pc}, {2'b11, 32'h2004});
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("redir_hold{ov,rv,ir}", {out_valid, redir_valid, in_ready}, 64'b010);
      tick();
    end
    redir_ack = 1'b1;
    @(negedge clk);
    check("redir_ack_cycle_rv", 64'(redir_valid), 64'd1);
    tick();
    redir_ack = 1'b0;
    @(negedge clk);
    check("redir_done{rv,ir}", {redir_valid, in_ready}, 64'b01);
    tick();

    // Stall on a non-mispredict result, then flush
    out_ready = 1'b0;
    drive_op(tbl[0]);
    @(negedge clk);
    check("stall1{ov,tk,ir,npc}", {out_valid, out_taken, in_ready, out_next_pc},
          {3'b110, 32'h1020});
    tick();
    flush = 1'b1;
    @(negedge clk);
    check("stall2_flush{ov,ir,npc}", {out_valid, in_ready, out_next_pc}, {2'b10, 32'h1020});
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("after_flush{ov,ir}", {out_valid, in_ready}, 64'b01);
    dummy = exp_q.pop_front();
    tick();

    // Stall on a mispredict result: flush ignored, early ack is remembered
    drive_op(tbl[3]);
    flush = 1'b1;
    @(negedge clk);
    check("misp_flush_ir", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("misp_after_flush{ov,rv}", {out_valid, redir_valid}, 64'b11);
    tick();
    redir_ack = 1'b1;
    @(negedge clk);
    check("early_ack_cycle_rv", 64'(redir_valid), 64'd1);
    tick();
    redir_ack = 1'b0;
    @(negedge clk);
    check("early_ack_after{ov,rv}", {out_valid, redir_valid}, 64'b10);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("early_ack_idle{ov,rv,ir}", {out_valid, redir_valid, in_ready}, 64'b001);
    tick();
    check("misp_drain", 64'(exp_q.size()), 64'd0);

`ifdef BRANCH_STATS_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    @(negedge clk);
    check("stats_clr", {stat_branches, stat_mispredicts}, 64'd0);
    tick();
    redir_ack = 1'b1;
    drive_op(tbl[0]); drive_op(tbl[1]); drive_op(tbl[2]);
    drive_op(tbl[3]); drive_op(tbl[5]);
    drain();
    check("stats_count", {stat_branches, stat_mispredicts}, {32'd5, 32'd2});
    stat_clr = 1'b1;
    drive_op(tbl[1]);
    stat_clr = 1'b0;
    @(negedge clk);
    check("stats_clr_vs_accept", {stat_branches, stat_mispredicts}, 64'd0);
    drain();
    redir_ack = 1'b0;
`endif

    // Reset asserted while in REDIR
    out_ready = 1'b1;
    drive_op(tbl[3]);
    tick();
    #1;
    check("pre_reset_redir_rv", 64'(redir_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset{ov,rv,npc}", {out_valid, redir_valid, out_next_pc}, 64'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset{ov,rv,ir}", {out_valid, redir_valid, in_ready}, 64'b001);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
